dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive CPU grants allowed while DMA waits.
REQ-002 SHALL have parameter TIMEOUT, default 16: BUSY cycles without mem_ack_i before abort.
REQ-003 SHALL run on one clock and an asynchronous, active-low reset: clk_i  in  1  rising-edge clock; rst_i  in  1  async active-low reset.
REQ-004 SHALL have port start_i  in  1  arbitration enable; low blocks new grants.
REQ-005 SHALL have CPU ports: cpu_req_i in 1 MEM-stage request (held until done); cpu_we_i in 1 write; cpu_addr_i in 32; cpu_wdata_i in 32; cpu_rdata_o out 32; cpu_stall_o out 1 stall to hazard unit.
REQ-006 SHALL have DMA ports: dma_req_i in 1 (held until done); dma_we_i in 1; dma_addr_i in 32; dma_wdata_i in 32; dma_rdata_o out 32; dma_done_o out 1.
REQ-007 SHALL have memory ports: mem_req_o out 1; mem_we_o out 1; mem_addr_o out 32; mem_wdata_o out 32; mem_rdata_i in 32; mem_ack_i in 1 one-cycle completion.
REQ-008 SHALL have status ports: grant_o out 2 (00 none, 01 CPU, 10 DMA); err_o out 1 one-cycle abort/misalign pulse.

Function
REQ-009 SHALL implement FSM IDLE, BUSY, DONE; only IDLE arbitrates.
REQ-010 IDLE: start_i=1 with any request -> latch winner's we/addr/wdata, set grant_o, go BUSY; else stay IDLE.
REQ-011 Priority: CPU wins by default; DMA wins if dma_req_i=1 and starve count == STARVE_LIMIT.
REQ-012 Starve count: +1 per CPU grant while dma_req_i=1; cleared on DMA grant or when arbitrating with dma_req_i=0; saturates at STARVE_LIMIT.
REQ-013 mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o SHALL be registered, driven from latched values only in BUSY; mem_req_o high the cycle after the grant edge.
REQ-014 BUSY: mem_ack_i=1 -> capture mem_rdata_i into owner's rdata register (reads only; writes keep it), go DONE.
REQ-015 BUSY: TIMEOUT cycles without ack -> drop mem_req_o, owner's rdata = 0, err_o pulse in DONE, go DONE.
REQ-016 Misaligned latched addr[1:0] != 0 -> no mem_req_o; IDLE -> DONE directly with err_o pulse, rdata unchanged.
REQ-017 DONE lasts exactly one cycle: dma_done_o=1 if DMA owned, grant_o cleared on exit, then IDLE; no grant in DONE, so a held request is not re-served.
REQ-018 cpu_stall_o = cpu_req_i AND NOT (state DONE AND owner CPU), combinational.
REQ-019 Minimum access: 3 cycles (IDLE, BUSY with ack, DONE); latency grows 1 per delayed ack cycle.
REQ-020 mem_ack_i outside BUSY SHALL be ignored.
REQ-021 start_i falling mid-access SHALL not abort; access completes normally.
REQ-022 Simultaneous CPU and DMA requests at count < STARVE_LIMIT -> CPU wins; DMA stays pending, not lost.
REQ-023 Request inputs SHALL be sampled only in IDLE; changes during BUSY ignored.

Reset
REQ-024 rst_i low SHALL immediately force state IDLE, all outputs 0 (cpu_stall_o = cpu_req_i), starve count 0, timer 0, rdata registers 0.
REQ-025 Reset mid-access SHALL drop mem_req_o at once; no done/err pulse follows reset release.

Structure
REQ-026 Package dmem_arb_pkg SHALL hold the state enum, grant_o encodings (GRANT_NONE/CPU/DMA) and default parameter constants.
REQ-027 Timeout counting SHALL be one sub-module arb_timer: clearable up-counter with terminal-count flag at TIMEOUT.

Verification
REQ-028 CPU read addr 0x08, memory acks on 2nd BUSY cycle, rdata 0x1234 -> cpu_rdata_o=0x1234, cpu_stall_o high 3 cycles, low in DONE.
REQ-029 CPU and DMA held continuously, STARVE_LIMIT=4 -> grant sequence CPU x4, DMA, CPU x4, DMA; dma_done_o pulses once per DMA grant.
REQ-030 DMA write addr 0x1C data 0xDEADBEEF, no ack -> mem_req_o high 16 cycles, err_o pulse, dma_rdata_o=0, return to IDLE.
REQ-031 CPU addr 0x06 -> mem_req_o never asserted, err_o pulse in DONE, cpu_stall_o low in DONE.
REQ-032 rst_i low during BUSY -> mem_req_o=0, grant_o=00 same cycle; no done/err after release; next request served normally.
REQ-033 start_i=0 with CPU pending -> no grant, cpu_stall_o held high; start_i=1 -> grant next edge.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared definitions for the data-memory arbiter:
//   - arbiter FSM state encoding
//   - grant_o encodings reported to the outside world
//   - default values for the STARVE_LIMIT / TIMEOUT parameters
//   - bus widths and a word-alignment helper
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_CPU  = 2'b01;
  localparam logic [1:0] GRANT_DMA  = 2'b10;

  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_TIMEOUT      = 16;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Only word accesses are supported; any non-zero byte offset is an error.
  function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/arb_timer.sv
// arb_timer
//   Clearable up-counter used to bound how long the arbiter waits for a
//   memory acknowledge.
//   Ports:
//     clk_i  in  rising-edge clock
//     rst_i  in  asynchronous active-low reset
//     clr    in  synchronous clear (held while not waiting on memory)
//     en     in  count one waiting cycle
//     tc     out high during the TIMEOUT-th enabled cycle since the last clear
module arb_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of enabled cycles already completed, so the cycle
  // in which it equals TIMEOUT-1 is the TIMEOUT-th one.
  assign tc = en && (cnt == LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Arbitrates a single data-memory port between the CPU MEM stage and a
//   DMA engine. One access at a time: IDLE arbitrates, BUSY waits for the
//   memory acknowledge (bounded by TIMEOUT), DONE reports completion for one
//   cycle. CPU has priority unless the DMA has been passed over
//   STARVE_LIMIT times in a row.
//   Ports:
//     clk_i, rst_i                 clock, asynchronous active-low reset
//     start_i                      arbitration enable (low blocks new grants)
//     cpu_req_i/we/addr/wdata      CPU request, held until served
//     cpu_rdata_o, cpu_stall_o     CPU read data, stall to hazard unit
//     dma_req_i/we/addr/wdata      DMA request, held until served
//     dma_rdata_o, dma_done_o      DMA read data, one-cycle completion pulse
//     mem_req/we/addr/wdata_o      registered memory request
//     mem_rdata_i, mem_ack_i       memory read data, one-cycle completion
//     grant_o                      current owner (00 none, 01 CPU, 10 DMA)
//     err_o                        one-cycle timeout / misalignment pulse
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              dma_done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o,
  output logic              err_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              arb_go, cpu_wins, own_dma;
  logic              sel_we, sel_mis;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              timer_clr, timer_en, timer_tc;

  arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (timer_clr),
    .en    (timer_en),
    .tc    (timer_tc)
  );

  // Arbitration decision, evaluated every cycle but only acted on in IDLE.
  always_comb begin
    cpu_wins  = cpu_req_i && !(dma_req_i && (starve_q == STARVE_MAX));
    arb_go    = (state_q == ST_IDLE) && start_i && (cpu_req_i || dma_req_i);
    sel_we    = cpu_wins ? cpu_we_i    : dma_we_i;
    sel_addr  = cpu_wins ? cpu_addr_i  : dma_addr_i;
    sel_wdata = cpu_wins ? cpu_wdata_i : dma_wdata_i;
    sel_mis   = misaligned(sel_addr);
    own_dma   = (grant_o == GRANT_DMA);
    // A CPU win with DMA waiting implies starve_q < STARVE_MAX, so the
    // increment saturates on its own. Every other arbitration clears it.
    if (cpu_wins && dma_req_i) starve_d = starve_q + SW'(1);
    else                       starve_d = '0;
    timer_clr = (state_q != ST_BUSY);
    timer_en  = (state_q == ST_BUSY);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (arb_go) state_d = sel_mis ? ST_DONE : ST_BUSY;
      ST_BUSY: if (mem_ack_i || timer_tc) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // The mem_* registers double as the latched copy of the winning request;
  // they are loaded on the grant edge and cleared when BUSY ends, so they
  // are non-zero only during BUSY.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      grant_o     <= GRANT_NONE;
      starve_q    <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      cpu_rdata_o <= '0;
      dma_rdata_o <= '0;
      err_o       <= 1'b0;
      dma_done_o  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_go) begin
            grant_o  <= cpu_wins ? GRANT_CPU : GRANT_DMA;
            starve_q <= starve_d;
            if (sel_mis) begin
              // Skip the bus entirely and report the error in DONE.
              err_o      <= 1'b1;
              dma_done_o <= !cpu_wins;
            end else begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= sel_we;
              mem_addr_o  <= sel_addr;
              mem_wdata_o <= sel_wdata;
            end
          end
        end
        ST_BUSY: begin
          if (mem_ack_i || timer_tc) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            dma_done_o  <= own_dma;
            if (mem_ack_i) begin
              // An ack on the last allowed cycle still counts as success.
              if (!mem_we_o) begin
                if (own_dma) dma_rdata_o <= mem_rdata_i;
                else         cpu_rdata_o <= mem_rdata_i;
              end
            end else begin
              err_o <= 1'b1;
              if (own_dma) dma_rdata_o <= '0;
              else         cpu_rdata_o <= '0;
            end
          end
        end
        ST_DONE: begin
          grant_o    <= GRANT_NONE;
          err_o      <= 1'b0;
          dma_done_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Release the CPU during the single DONE cycle of its own access.
  assign cpu_stall_o = cpu_req_i && !((state_q == ST_DONE) && (grant_o == GRANT_CPU));

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int SL = 4;
  localparam int TO = 16;
  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_CPU  = 2'b01;
  localparam logic [1:0] G_DMA  = 2'b10;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0, cpu_wdata_i = '0;
  logic [31:0] cpu_rdata_o;
  logic        cpu_stall_o;
  logic        dma_req_i = 1'b0, dma_we_i = 1'b0;
  logic [31:0] dma_addr_i = '0, dma_wdata_i = '0;
  logic [31:0] dma_rdata_o;
  logic        dma_done_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;
  logic [1:0]  grant_o;
  logic        err_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          m_starve;
  logic [31:0] m_cpu_rd, m_dma_rd;

  dmem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
    .dma_wdata_i(dma_wdata_i), .dma_rdata_o(dma_rdata_o), .dma_done_o(dma_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .grant_o(grant_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, n_vec=%0d", n_vec);
    $fatal(1);
  end

  task automatic do_reset();
    rst_i = 1'b0; start_i = 1'b0; mem_ack_i = 1'b0;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    dma_req_i = 1'b0; dma_we_i = 1'b0; dma_addr_i = '0; dma_wdata_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    m_starve = 0; m_cpu_rd = '0; m_dma_rd = '0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    cpu_req_i = 1'b1;
    #1;
    n_vec++;
    if ({grant_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o, dma_done_o,
         cpu_rdata_o, dma_rdata_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: grant=%b mem_req=%b err=%b done=%b cpu_rd=%h dma_rd=%h, expected all 0",
               grant_o, mem_req_o, err_o, dma_done_o, cpu_rdata_o, dma_rdata_o);
    end
    n_vec++;
    if (cpu_stall_o !== 1'b1) begin
      n_err++; $display("FAIL reset_stall: got %b expected 1", cpu_stall_o);
    end
    cpu_req_i = 1'b0;
    #1;
    n_vec++;
    if (cpu_stall_o !== 1'b0) begin
      n_err++; $display("FAIL reset_stall_idle: got %b expected 0", cpu_stall_o);
    end
  endtask

  task automatic test_cpu_read();
    int stall_cnt;
    do_reset();
    // An ack while idle must not disturb anything.
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_0001;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    n_vec++;
    if (cpu_rdata_o !== 32'h0 || grant_o !== G_NONE) begin
      n_err++; $display("FAIL idle_ack_ignored: rdata=%h grant=%b expected 0/00", cpu_rdata_o, grant_o);
    end
    stall_cnt = 0;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h8; start_i = 1'b1;
    #1; if (cpu_stall_o) stall_cnt++;
    @(negedge clk_i);
    if (cpu_stall_o) stall_cnt++;
    n_vec++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8 || mem_we_o !== 1'b0 || grant_o !== G_CPU) begin
      n_err++; $display("FAIL cpu_read_bus: req=%b addr=%h we=%b grant=%b expected 1/00000008/0/01",
                        mem_req_o, mem_addr_o, mem_we_o, grant_o);
    end
    @(negedge clk_i);
    if (cpu_stall_o) stall_cnt++;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1234;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    n_vec++;
    if (cpu_rdata_o !== 32'h1234) begin
      n_err++; $display("FAIL cpu_read_rdata: got %h expected 00001234", cpu_rdata_o);
    end
    n_vec++;
    if (cpu_stall_o !== 1'b0 || err_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_err++; $display("FAIL cpu_read_done: stall=%b err=%b mem_req=%b expected 0/0/0", cpu_stall_o, err_o, mem_req_o);
    end
    n_vec++;
    if (stall_cnt != 3) begin
      n_err++; $display("FAIL cpu_read_stall_cycles: got %0d expected 3", stall_cnt);
    end
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if (grant_o !== G_NONE || mem_req_o !== 1'b0) begin
      n_err++; $display("FAIL cpu_read_idle: grant=%b mem_req=%b expected 00/0", grant_o, mem_req_o);
    end
  endtask

  task automatic test_starve();
    logic [1:0] seq [10];
    logic [1:0] prev, exp_g;
    int ng, ndone, cnt, ndma;
    do_reset();
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h40;
    dma_req_i = 1'b1; dma_we_i = 1'b0; dma_addr_i = 32'h80;
    mem_rdata_i = 32'h7777; start_i = 1'b1;
    prev = G_NONE; ng = 0; ndone = 0;
    for (int c = 0; c < 80 && ng < 10; c++) begin
      @(negedge clk_i);
      mem_ack_i = mem_req_o;
      if (dma_done_o) ndone++;
      if (grant_o != G_NONE && prev == G_NONE) begin seq[ng] = grant_o; ng++; end
      prev = grant_o;
    end
    cpu_req_i = 1'b0; dma_req_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      mem_ack_i = mem_req_o;
      if (dma_done_o) ndone++;
    end
    mem_ack_i = 1'b0;
    n_vec++;
    if (ng != 10) begin
      n_err++; $display("FAIL starve_grant_count: got %0d expected 10", ng);
    end
    cnt = 0; ndma = 0;
    for (int i = 0; i < 10 && i < ng; i++) begin
      if (cnt == SL) begin exp_g = G_DMA; cnt = 0; ndma++; end
      else begin exp_g = G_CPU; cnt = (cnt < SL) ? cnt + 1 : SL; end
      n_vec++;
      if (seq[i] !== exp_g) begin
        n_err++; $display("FAIL starve_seq[%0d]: got %b expected %b", i, seq[i], exp_g);
      end
    end
    n_vec++;
    if (ndone != ndma) begin
      n_err++; $display("FAIL starve_dma_done: got %0d pulses expected %0d", ndone, ndma);
    end
  endtask

  task automatic test_timeout();
    int nreq;
    logic seen_err, bad, got;
    do_reset();
    dma_req_i = 1'b1; dma_we_i = 1'b0; dma_addr_i = 32'h20; start_i = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (mem_req_o) begin mem_ack_i = 1'b1; mem_rdata_i = 32'hA5A5_5A5A; got = 1'b1; break; end
    end
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    n_vec++;
    if (!got || dma_rdata_o !== 32'hA5A5_5A5A || dma_done_o !== 1'b1) begin
      n_err++; $display("FAIL dma_read: rdata=%h done=%b expected a5a55a5a/1", dma_rdata_o, dma_done_o);
    end
    dma_req_i = 1'b0;
    @(negedge clk_i);
    dma_req_i = 1'b1; dma_we_i = 1'b1; dma_addr_i = 32'h1C; dma_wdata_i = 32'hDEADBEEF;
    nreq = 0; seen_err = 1'b0; bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (mem_req_o) begin
        nreq++;
        if (mem_addr_o !== 32'h1C || mem_wdata_o !== 32'hDEADBEEF || mem_we_o !== 1'b1) bad = 1'b1;
      end
      if (err_o) begin
        seen_err = 1'b1;
        n_vec++;
        if (dma_rdata_o !== 32'h0 || dma_done_o !== 1'b1 || mem_req_o !== 1'b0) begin
          n_err++; $display("FAIL timeout_done: rdata=%h done=%b mem_req=%b expected 0/1/0",
                            dma_rdata_o, dma_done_o, mem_req_o);
        end
        break;
      end
    end
    dma_req_i = 1'b0;
    n_vec++;
    if (!seen_err || nreq != TO || bad) begin
      n_err++; $display("FAIL timeout_req_cycles: err_seen=%b req_cycles=%0d bus_bad=%b expected 1/%0d/0",
                        seen_err, nreq, bad, TO);
    end
    @(negedge clk_i);
    n_vec++;
    if (grant_o !== G_NONE || err_o !== 1'b0 || dma_done_o !== 1'b0) begin
      n_err++; $display("FAIL timeout_idle: grant=%b err=%b done=%b expected 00/0/0", grant_o, err_o, dma_done_o);
    end
  endtask

  task automatic test_misaligned();
    logic saw_req, saw_err;
    do_reset();
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h10; start_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (mem_req_o) begin mem_ack_i = 1'b1; mem_rdata_i = 32'h55; break; end
    end
    @(negedge clk_i);
    mem_ack_i = 1'b0; cpu_req_i = 1'b0;
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_addr_i = 32'h6;
    saw_req = 1'b0; saw_err = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (mem_req_o) saw_req = 1'b1;
      if (err_o) begin
        saw_err = 1'b1;
        n_vec++;
        if (cpu_stall_o !== 1'b0 || cpu_rdata_o !== 32'h55 || grant_o !== G_CPU) begin
          n_err++; $display("FAIL misalign_done: stall=%b rdata=%h grant=%b expected 0/00000055/01",
                            cpu_stall_o, cpu_rdata_o, grant_o);
        end
        break;
      end
    end
    cpu_req_i = 1'b0;
    n_vec++;
    if (saw_req || !saw_err) begin
      n_err++; $display("FAIL misalign_bus: mem_req_seen=%b err_seen=%b expected 0/1", saw_req, saw_err);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid();
    logic bad, got;
    do_reset();
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h30; start_i = 1'b1;
    @(negedge clk_i);
    n_vec++;
    if (mem_req_o !== 1'b1) begin
      n_err++; $display("FAIL rstmid_busy: mem_req=%b expected 1", mem_req_o);
    end
    rst_i = 1'b0;
    #1;
    n_vec++;
    if (mem_req_o !== 1'b0 || grant_o !== G_NONE) begin
      n_err++; $display("FAIL rstmid_async: mem_req=%b grant=%b expected 0/00", mem_req_o, grant_o);
    end
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      if (err_o || dma_done_o || grant_o != G_NONE || mem_req_o) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++; $display("FAIL rstmid_no_pulse: activity after release got 1 expected 0");
    end
    dma_req_i = 1'b1; dma_we_i = 1'b0; dma_addr_i = 32'h44;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (mem_req_o) begin mem_ack_i = 1'b1; mem_rdata_i = 32'h600DF00D; got = 1'b1; break; end
    end
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    n_vec++;
    if (!got || dma_rdata_o !== 32'h600DF00D || dma_done_o !== 1'b1) begin
      n_err++; $display("FAIL rstmid_next: rdata=%h done=%b expected 600df00d/1", dma_rdata_o, dma_done_o);
    end
    dma_req_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_start_gate();
    logic bad;
    do_reset();
    start_i = 1'b0;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h50;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      if (grant_o !== G_NONE || mem_req_o !== 1'b0 || cpu_stall_o !== 1'b1) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++; $display("FAIL start_blocked: grant=%b mem_req=%b stall=%b expected 00/0/1",
                        grant_o, mem_req_o, cpu_stall_o);
    end
    start_i = 1'b1;
    @(negedge clk_i);
    n_vec++;
    if (grant_o !== G_CPU || mem_req_o !== 1'b1) begin
      n_err++; $display("FAIL start_grant: grant=%b mem_req=%b expected 01/1", grant_o, mem_req_o);
    end
    start_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if (mem_req_o !== 1'b1) begin
      n_err++; $display("FAIL start_drop_busy: mem_req=%b expected 1", mem_req_o);
    end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h5151_A0A0;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    n_vec++;
    if (cpu_rdata_o !== 32'h5151_A0A0 || cpu_stall_o !== 1'b0) begin
      n_err++; $display("FAIL start_drop_done: rdata=%h stall=%b expected 5151a0a0/0", cpu_rdata_o, cpu_stall_o);
    end
    cpu_req_i = 1'b0;
    @(negedge clk_i);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom & 32'h0000_FFFC;
    if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic test_random();
    logic        cp, dp, win_dma, mis, acked, e_we, bus_bad, e_err;
    logic [31:0] e_addr, e_wdata, rd;
    logic [1:0]  e_grant;
    int          dly;
    do_reset();
    start_i = 1'b1;
    cp = 1'b0; dp = 1'b0;
    for (int t = 0; t < 80; t++) begin
      if (!cp && $urandom_range(0, 3) != 0) begin
        cp = 1'b1; cpu_we_i = 1'($urandom_range(0, 1)); cpu_addr_i = rand_addr(); cpu_wdata_i = $urandom;
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1'b1; dma_we_i = 1'($urandom_range(0, 1)); dma_addr_i = rand_addr(); dma_wdata_i = $urandom;
      end
      cpu_req_i = cp; dma_req_i = dp;
      if (!cp && !dp) begin
        @(negedge clk_i);
        n_vec++;
        if (grant_o !== G_NONE) begin
          n_err++; $display("FAIL rnd_idle_grant: got %b expected 00", grant_o);
        end
        continue;
      end
      // Reference arbitration
      win_dma = dp && (!cp || m_starve == SL);
      if (win_dma)  m_starve = 0;
      else if (dp)  m_starve = (m_starve < SL) ? m_starve + 1 : SL;
      else          m_starve = 0;
      e_grant = win_dma ? G_DMA : G_CPU;
      e_we    = win_dma ? dma_we_i : cpu_we_i;
      e_addr  = win_dma ? dma_addr_i : cpu_addr_i;
      e_wdata = win_dma ? dma_wdata_i : cpu_wdata_i;
      mis     = (e_addr[1:0] != 2'b00);
      dly     = ($urandom_range(0, 4) == 0) ? TO + 1 : $urandom_range(0, 3);
      acked   = 1'b0;
      rd      = '0;
      @(negedge clk_i);
      n_vec++;
      if (grant_o !== e_grant) begin
        n_err++; $display("FAIL rnd_grant[%0d]: got %b expected %b", t, grant_o, e_grant);
      end
      if (!mis) begin
        bus_bad = 1'b0;
        for (int k = 0; k < TO; k++) begin
          if (mem_req_o !== 1'b1 || mem_addr_o !== e_addr || mem_we_o !== e_we ||
              (e_we && mem_wdata_o !== e_wdata)) bus_bad = 1'b1;
          rd = $urandom;
          mem_rdata_i = rd;
          mem_ack_i = (k == dly);
          @(negedge clk_i);
          if (k == dly) begin acked = 1'b1; break; end
        end
        mem_ack_i = 1'b0;
        n_vec++;
        if (bus_bad) begin
          n_err++; $display("FAIL rnd_bus[%0d]: got mismatching bus expected addr=%h we=%b", t, e_addr, e_we);
        end
      end
      // Expected completion
      e_err = mis || !acked;
      if (!mis) begin
        if (!acked) begin
          if (win_dma) m_dma_rd = '0; else m_cpu_rd = '0;
        end else if (!e_we) begin
          if (win_dma) m_dma_rd = rd; else m_cpu_rd = rd;
        end
      end
      n_vec++;
      if (err_o !== e_err || dma_done_o !== win_dma || mem_req_o !== 1'b0) begin
        n_err++; $display("FAIL rnd_done[%0d]: err=%b done=%b mem_req=%b expected %b/%b/0",
                          t, err_o, dma_done_o, mem_req_o, e_err, win_dma);
      end
      n_vec++;
      if (cpu_rdata_o !== m_cpu_rd || dma_rdata_o !== m_dma_rd) begin
        n_err++; $display("FAIL rnd_rdata[%0d]: cpu=%h dma=%h expected %h/%h",
                          t, cpu_rdata_o, dma_rdata_o, m_cpu_rd, m_dma_rd);
      end
      n_vec++;
      if (cpu_stall_o !== (cp && win_dma)) begin
        n_err++; $display("FAIL rnd_stall[%0d]: got %b expected %b", t, cpu_stall_o, cp && win_dma);
      end
      if (win_dma) dp = 1'b0; else cp = 1'b0;
      cpu_req_i = cp; dma_req_i = dp;
      @(negedge clk_i);
      n_vec++;
      if (grant_o !== G_NONE || err_o !== 1'b0 || dma_done_o !== 1'b0) begin
        n_err++; $display("FAIL rnd_idle[%0d]: grant=%b err=%b done=%b expected 00/0/0",
                          t, grant_o, err_o, dma_done_o);
      end
    end
    cpu_req_i = 1'b0; dma_req_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_starve();
    test_timeout();
    test_misaligned();
    test_reset_mid();
    test_start_gate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
